// File: rtl/sseg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package sseg_arb_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MAX_SRC = 8;

  typedef enum logic [0:0] {
    StIdle,
    StOwn
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i, ascending with wrap.
module rr_pick #(
  parameter int unsigned NumSrc = 4,
  localparam int unsigned IdxW  = $clog2(NumSrc)
) (
  input  logic [NumSrc-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumSrc-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  int unsigned      cand;
  logic [IdxW-1:0]  cand_idx;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NumSrc - 1; k >= 0; k--) begin
      cand     = (32'(ptr_i) + 32'(k)) % NumSrc;
      cand_idx = IdxW'(cand);
      if (req_i[cand_idx]) begin
        gnt_o          = '0;
        gnt_o[cand_idx] = 1'b1;
        idx_o          = cand_idx;
        valid_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner of the shared 4-digit seven-segment driver with minimum dwell per owner.
// Optional SSEG_ARB_PREEMPT_EN: source 0 preempts and holds while it requests.
module sseg_display_arbiter
  import sseg_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_CYCLES = 100_000_000
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_SRC-1:0]        req_i,
  input  logic [DATA_W*NUM_SRC-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]        src_hex_dec_i,
  input  logic [NUM_SRC-1:0]        src_sign_i,
  input  logic                      freeze_i,
  output logic [NUM_SRC-1:0]        grant_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      hex_dec_o,
  output logic                      sign_o,
  output logic                      active_o
);

  localparam int unsigned IdxW = $clog2(NUM_SRC);
  localparam int unsigned CntW = $clog2(DWELL_CYCLES);

  if (NUM_SRC < 2 || NUM_SRC > MAX_SRC) begin : g_bad_cfg
    $error("sseg_display_arbiter: NUM_SRC out of range");
  end

  arb_state_e         state_q, state_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               hex_q, hex_d;
  logic               sign_q, sign_d;
  logic               active_q, active_d;

  logic [NUM_SRC-1:0] pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_vld;
  logic               take;
  logic               owner_req;
  logic               dwell_done;
  logic               preempt;
  logic               src0_hold;

  // The current owner is masked out so the picker only ever returns a different source.
  rr_pick #(
    .NumSrc (NUM_SRC)
  ) u_rr_pick (
    .req_i   (req_i & ~grant_q),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  assign owner_req  = req_i[owner_q];
  assign dwell_done = (cnt_q == CntW'(DWELL_CYCLES - 1));

`ifdef SSEG_ARB_PREEMPT_EN
  // ptr_q is left untouched on preemption, so release resumes the saved rotation.
  assign preempt   = (state_q == StOwn) && req_i[0] && (owner_q != '0);
  assign src0_hold = (owner_q == '0);
`else
  assign preempt   = 1'b0;
  assign src0_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    take    = 1'b0;

    unique case (state_q)
      StIdle: begin
        take = pick_vld;
      end
      StOwn: begin
        if (preempt) begin
          owner_d    = '0;
          grant_d    = '0;
          grant_d[0] = 1'b1;
          cnt_d      = '0;
        end else if (!owner_req) begin
          if (pick_vld) begin
            take = 1'b1;
          end else begin
            state_d = StIdle;
            owner_d = '0;
            grant_d = '0;
            cnt_d   = '0;
          end
        end else if (!freeze_i && !src0_hold) begin
          if (dwell_done) begin
            take  = pick_vld;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase

    if (take) begin
      state_d = StOwn;
      owner_d = pick_idx;
      grant_d = pick_gnt;
      cnt_d   = '0;
      ptr_d   = (pick_idx == IdxW'(NUM_SRC - 1)) ? '0 : pick_idx + IdxW'(1);
    end

    active_d = (state_d == StOwn);
    data_d   = '0;
    hex_d    = 1'b0;
    sign_d   = 1'b0;
    if (active_d) begin
      data_d = src_data_i[int'(owner_d)*DATA_W +: DATA_W];
      hex_d  = src_hex_dec_i[owner_d];
      sign_d = src_sign_i[owner_d];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      hex_q    <= 1'b0;
      sign_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      hex_q    <= hex_d;
      sign_q   <= sign_d;
      active_q <= active_d;
    end
  end

  assign grant_o   = grant_q;
  assign data_o    = data_q;
  assign hex_dec_o = hex_q;
  assign sign_o    = sign_q;
  assign active_o  = active_q;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Scoreboard bench for sseg_display_arbiter (NUM_SRC=4, DWELL_CYCLES=4), directed vectors.
module tb_sseg_display_arbiter;

  localparam int NS = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] req;
  logic [63:0]   src_data;
  logic [NS-1:0] src_hex = 4'b0101;
  logic [NS-1:0] src_sign = 4'b1010;
  logic          freeze;
  logic [NS-1:0] grant;
  logic [15:0]   data;
  logic          hex_dec;
  logic          sign;
  logic          active;

  logic [15:0] sval [NS];
  assign src_data = {sval[3], sval[2], sval[1], sval[0]};

  sseg_display_arbiter #(
    .NUM_SRC      (NS),
    .DWELL_CYCLES (DW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .src_data_i    (src_data),
    .src_hex_dec_i (src_hex),
    .src_sign_i    (src_sign),
    .freeze_i      (freeze),
    .grant_o       (grant),
    .data_o        (data),
    .hex_dec_o     (hex_dec),
    .sign_o        (sign),
    .active_o      (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          own;
    logic [15:0] d;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Push the expectation for the edge following this negedge, then advance one cycle.
  task automatic cyc(input int own);
    exp_t e;
    e.own = own;
    e.d   = (own < 0) ? 16'h0000 : sval[own];
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic cycn(input int own, input int n);
    for (int i = 0; i < n; i++) cyc(own);
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if (grant !== '0 || data !== '0 || active !== 1'b0 || hex_dec !== 1'b0 || sign !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: grant=%b data=%h active=%b hex=%b sign=%b, required all zero",
               name, grant, data, active, hex_dec, sign);
    end
  endtask

  exp_t          me;
  logic [NS-1:0] eg;
  logic          eh, es, ea;

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      me = q.pop_front();
      eg = (me.own < 0) ? '0 : NS'(1) << me.own;
      ea = (me.own >= 0);
      eh = (me.own < 0) ? 1'b0 : src_hex[me.own];
      es = (me.own < 0) ? 1'b0 : src_sign[me.own];
      n_vec++;
      if (grant !== eg || data !== me.d || active !== ea || hex_dec !== eh || sign !== es) begin
        n_bad++;
        $display("FAIL vec%0d t=%0t: grant=%b data=%h act=%b hex=%b sign=%b, required %b %h %b %b %b",
                 n_vec, $time, grant, data, active, hex_dec, sign, eg, me.d, ea, eh, es);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    req     = 4'b1111;
    freeze  = 1'b0;
    sval[0] = 16'h00AB;
    sval[1] = 16'h00CD;
    sval[2] = 16'h1234;
    sval[3] = 16'hFFFF;

    // Reset held with all requests pending, then full rotation.
    repeat (3) @(negedge clk);
    #1 check_zero("reset_hold");
    rst_n = 1'b1;
    cycn(0, 4);
    cycn(1, 4);
    cycn(2, 4);
    cycn(3, 4);
    cyc(0);

    // Lone requester keeps the display; live data passes through.
    req = 4'b0100;
    cycn(2, 21);
    sval[2] = 16'h5678;
    cycn(2, 2);
    sval[2] = 16'h1234;

    // Owner release mid-dwell, then idle.
    req = 4'b0010;
    cyc(1);
    req = 4'b1010;
    cyc(1);
    req = 4'b1000;
    cyc(3);
    req = 4'b0000;
    cycn(-1, 2);

    // Freeze holds the dwell count; rotation resumes after the remainder.
    req = 4'b1111;
    cycn(0, 2);
    freeze = 1'b1;
    cycn(0, 10);
    freeze = 1'b0;
    cycn(0, 2);
    cycn(1, 2);

    // Asynchronous reset mid-dwell.
    rst_n = 1'b0;
    #1 check_zero("reset_mid");
    cycn(-1, 2);
    req   = 4'b0100;
    rst_n = 1'b1;
    cyc(2);

    // Source 0 arrives while source 2 owns.
    req = 4'b1101;
`ifdef SSEG_ARB_PREEMPT_EN
    cycn(0, 6);
    req = 4'b1100;
    cycn(3, 2);
`else
    cycn(2, 3);
    cycn(3, 4);
    cyc(0);
`endif

    req = 4'b0000;
    cycn(-1, 2);
    repeat (2) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
